// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared FSM/op encodings and default sizing for multdiv_sequencer
package multdiv_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W = $clog2(WIDTH_DEF);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  typedef enum logic {OP_MULT, OP_DIV} op_t;
endpackage

// File: rtl/multdiv_sequencer_negator.sv
// twos_negator: combinational two's-complement negation (invert + 1, modulo 2^WIDTH)
module twos_negator #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = ~i_a + WIDTH'(1);
endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: iterative signed multiply / restoring divide; MULTDIV_OVF_EN adds overflow flagging
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t r_state, w_next;
  op_t r_op;
  logic [WIDTH-1:0] r_a, r_b, r_m, r_result;
  logic [2*WIDTH-1:0] r_acc, w_step;
  logic [CW-1:0] r_cnt;
  logic r_sign, r_exc;
  logic w_start, w_div0, w_last, w_ovf;
  logic [WIDTH-1:0] w_na, w_nb, w_nq, w_ma, w_mb, w_fix;
  logic [WIDTH:0] w_sum, w_shift, w_trial;
  twos_negator #(.WIDTH(WIDTH)) u_neg_a (.i_a(r_a), .o_y(w_na));
  twos_negator #(.WIDTH(WIDTH)) u_neg_b (.i_a(r_b), .o_y(w_nb));
  twos_negator #(.WIDTH(WIDTH)) u_neg_q (.i_a(r_acc[WIDTH-1:0]), .o_y(w_nq));
  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_ma = r_a[WIDTH-1] ? w_na : r_a;
  assign w_mb = r_b[WIDTH-1] ? w_nb : r_b;
  assign w_div0 = (r_op == OP_DIV) && (r_b == '0);
  assign w_last = r_cnt == CW'(WIDTH - 1);
  // Multiply: accumulator upper half gathers partial sums, lower half holds the shifting multiplier.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{r_acc[0]}} & r_m};
  // Divide: upper half is the remainder, lower half shifts dividend bits out and quotient bits in.
  assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_m};
  assign w_step = (r_op == OP_MULT) ? {w_sum, r_acc[WIDTH-1:1]}
                : {w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_fix = r_sign ? w_nq : r_acc[WIDTH-1:0];
`ifdef MULTDIV_OVF_EN
  // A negative result may reach magnitude 2^(WIDTH-1); a positive one must stay below it.
  localparam logic [2*WIDTH-1:0] MIN_MAG = (2*WIDTH)'(1) << (WIDTH - 1);
  assign w_ovf = (r_op == OP_MULT) ? ((|r_acc[2*WIDTH-1:WIDTH-1]) && !(r_sign && r_acc == MIN_MAG))
               : (!r_sign && r_acc[WIDTH-1]);
`else
  assign w_ovf = 1'b0;
`endif
  assign data_result = r_result;
  assign data_exception = r_exc;
  // State register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  // Next state: any start restarts from PREP, overriding the current op
  always_comb
    w_next = w_start ? PREP
           : (r_state == PREP) ? (w_div0 ? DONE : RUN)
           : (r_state == RUN) ? (w_last ? FIX : RUN)
           : (r_state == FIX) ? DONE : IDLE;
  // Status outputs decoded from state
  always_comb begin
    data_resultRDY = r_state == DONE;
    busy = r_state != IDLE;
  end
  // Datapath: operand capture, magnitude prep, iteration, sign fix on entry to DONE
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_op <= OP_MULT;
      r_a <= '0;
      r_b <= '0;
      r_m <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_sign <= 1'b0;
      r_result <= '0;
      r_exc <= 1'b0;
    end else if (w_start) begin
      r_a <= data_operandA;
      r_b <= data_operandB;
      r_op <= ctrl_MULT ? OP_MULT : OP_DIV;
    end else if (r_state == PREP) begin
      r_sign <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
      r_m <= (r_op == OP_MULT) ? w_ma : w_mb;
      r_acc <= {{WIDTH{1'b0}}, (r_op == OP_MULT) ? w_mb : w_ma};
      r_cnt <= '0;
      if (w_div0) begin
        r_result <= '0;
        r_exc <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_acc <= w_step;
      r_cnt <= w_last ? r_cnt : r_cnt + CW'(1);
    end else if (r_state == FIX) begin
      r_result <= w_fix;
      r_exc <= w_ovf;
    end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed vectors against an arithmetic reference model plus literal checks
module tb_multdiv_sequencer;
  logic clock = 1'b0, reset_n = 1'b0, ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0, data_result;
  logic data_exception, data_resultRDY, busy;
  int errs = 0, checks = 0;
`ifdef MULTDIV_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  multdiv_sequencer dut (
    .clock(clock), .reset_n(reset_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .data_result(data_result),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference arithmetic: {exception, result} from the signed operands
  function automatic logic [32:0] expect_op(input bit mul, input logic [31:0] a, input logic [31:0] b);
    longint p;
    if (mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {OVF && (p != longint'($signed(p[31:0]))), p[31:0]};
    end
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {OVF, 32'h8000_0000};
    p = longint'($signed(a)) / longint'($signed(b));
    return {1'b0, p[31:0]};
  endfunction
  // Timing model: age counts edges since the sampling edge (which is edge 1)
  int m_age, m_lat;
  bit m_active;
  logic [31:0] m_res, m_pres;
  logic m_exc, m_pexc;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      m_active <= 0;
      m_age <= 0;
      m_lat <= 0;
      m_res <= '0;
      m_exc <= 1'b0;
      m_pres <= '0;
      m_pexc <= 1'b0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      {m_pexc, m_pres} <= expect_op(ctrl_MULT, data_operandA, data_operandB);
      m_lat <= (!ctrl_MULT && data_operandB == 32'h0) ? 2 : 35;
      m_age <= 1;
      m_active <= 1;
    end else if (m_active) begin
      m_age <= m_age + 1;
      if (m_age + 1 == m_lat) begin
        m_res <= m_pres;
        m_exc <= m_pexc;
      end
      if (m_age + 1 > m_lat) m_active <= 0;
    end
  // Every-cycle comparison against the model
  always @(negedge clock) begin
    chk("cyc_ready", data_resultRDY, m_active && m_age == m_lat);
    chk("cyc_busy", busy, m_active);
    chk("cyc_result", data_result, m_res);
    chk("cyc_exc", data_exception, m_exc);
  end
  task automatic start_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = mul;
    ctrl_DIV = div;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 0;
    ctrl_DIV = 0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask
  task automatic wait_ready(input string name, output int n);
    n = 1;
    while (!data_resultRDY && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!data_resultRDY) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask
  task automatic run(input string name, input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] res, input logic exc);
    int n;
    start_op(mul, div, a, b);
    wait_ready(name, n);
    chk({name, "_latency"}, n, lat);
    chk({name, "_result"}, data_result, res);
    chk({name, "_exc"}, data_exception, exc);
  endtask
  initial begin
    int pulses, first;
    #1;
    chk("rst_result", data_result, 0);
    chk("rst_exc", data_exception, 0);
    chk("rst_ready", data_resultRDY, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clock);
    reset_n = 1;
    run("mul_7_m3", 1, 0, 32'd7, -32'sd3, 35, 32'hFFFF_FFEB, 0);
    run("div_m100_7", 0, 1, -32'sd100, 32'd7, 35, 32'hFFFF_FFF2, 0);
    run("div_100_m7", 0, 1, 32'd100, -32'sd7, 35, 32'hFFFF_FFF2, 0);
    run("div_by_zero", 0, 1, 32'd5, 32'd0, 2, 32'h0, 1);
    @(negedge clock);
    chk("div0_busy_after", busy, 0);
    run("mul_wrap", 1, 0, 32'h0001_0000, 32'h0001_0000, 35, 32'h0, OVF);
    run("both_mult_wins", 1, 1, 32'd6, 32'd3, 35, 32'd18, 0);
    run("mul_neg_neg", 1, 0, -32'sd5, -32'sd6, 35, 32'd30, 0);
    run("div_7_m2", 0, 1, 32'd7, -32'sd2, 35, 32'hFFFF_FFFD, 0);
    run("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'h8000_0000, OVF);
    start_op(0, 1, 32'd1000, 32'd3);
    repeat (11) @(negedge clock);
    start_op(1, 0, 32'd3, 32'd4);
    pulses = 0;
    first = 0;
    for (int i = 1; i <= 50; i++) begin
      if (data_resultRDY) begin
        pulses++;
        if (first == 0) first = i;
      end
      @(negedge clock);
    end
    chk("abort_pulses", pulses, 1);
    chk("abort_latency", first, 35);
    chk("abort_result", data_result, 32'd12);
    start_op(1, 0, 32'h0000_1234, 32'h0000_5678);
    repeat (21) @(negedge clock);
    #2 reset_n = 0;
    #1;
    chk("midrst_result", data_result, 0);
    chk("midrst_exc", data_exception, 0);
    chk("midrst_ready", data_resultRDY, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clock);
    reset_n = 1;
    run("mul_min_1", 1, 0, 32'h8000_0000, 32'd1, 35, 32'h8000_0000, 0);
    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
